// File: rtl/wb_arbiter_if.sv
// Register-file writeback bus shared by the main pipeline, the multi-cycle unit and the arbiter.
// mdu_valid/mdu_ready: a result transfers on a rising edge where both are 1; the producer holds it until then.
interface wb_arbiter_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          pipe_we;
  logic [4:0]    pipe_addr;
  logic [31:0]   pipe_data;
  logic          mdu_valid;
  logic          mdu_ready;
  logic [4:0]    mdu_addr;
  logic [31:0]   mdu_data;
  logic          rf_we;
  logic [4:0]    rf_addr;
  logic [31:0]   rf_data;
  logic [4:0]    fwd_addr;
  logic          fwd_hit;
  logic [31:0]   fwd_data;
  logic [CW-1:0] pend_count;

  modport slave (
    input  pipe_we, pipe_addr, pipe_data, mdu_valid, mdu_addr, mdu_data, fwd_addr,
    output mdu_ready, rf_we, rf_addr, rf_data, fwd_hit, fwd_data, pend_count
  );

  modport master (
    output pipe_we, pipe_addr, pipe_data, mdu_valid, mdu_addr, mdu_data, fwd_addr,
    input  mdu_ready, rf_we, rf_addr, rf_data, fwd_hit, fwd_data, pend_count
  );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: the pipeline always wins the register-file port; MDU results wait in a
// small FIFO whose entries are killed when a younger pipeline write hits the same register.
module wb_arbiter #(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  wb_arbiter_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [4:0]       q_addr [DEPTH];
  logic [31:0]      q_data [DEPTH];
  logic [DEPTH-1:0] q_valid;
  logic [DEPTH-1:0] q_kill;
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [CW-1:0]    count;

  logic pipe_act;
  logic mdu_xfer;
  logic mdu_drop;
  logic pop;
  logic bypass;
  logic enq;

  assign bus.mdu_ready  = (count < CW'(DEPTH));
  assign bus.pend_count = count;

  always_comb begin
    pipe_act = bus.pipe_we && (bus.pipe_addr != 5'd0);
    mdu_xfer = bus.mdu_valid && bus.mdu_ready;
    // A same-cycle pipe write to the same register is younger, so the MDU value is stale.
    mdu_drop = (bus.mdu_addr == 5'd0) || (pipe_act && (bus.pipe_addr == bus.mdu_addr));
    pop      = !rst && !pipe_act && (count != '0);
    bypass   = !rst && !pipe_act && (count == '0) && mdu_xfer && !mdu_drop;
    enq      = !rst && mdu_xfer && !mdu_drop && !bypass;
  end

  always_comb begin
    bus.rf_we   = 1'b0;
    bus.rf_addr = 5'd0;
    bus.rf_data = 32'd0;
    if (!rst && pipe_act) begin
      bus.rf_we   = 1'b1;
      bus.rf_addr = bus.pipe_addr;
      bus.rf_data = bus.pipe_data;
    end else if (pop) begin
      bus.rf_we   = !q_kill[head];
      bus.rf_addr = q_addr[head];
      bus.rf_data = q_data[head];
    end else if (bypass) begin
      bus.rf_we   = 1'b1;
      bus.rf_addr = bus.mdu_addr;
      bus.rf_data = bus.mdu_data;
    end
  end

  // Walk oldest to youngest so the last live match is the youngest value.
  always_comb begin
    logic [PW-1:0] idx;
    idx          = '0;
    bus.fwd_hit  = 1'b0;
    bus.fwd_data = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (q_valid[idx] && !q_kill[idx] && (bus.fwd_addr != 5'd0) &&
          (q_addr[idx] == bus.fwd_addr)) begin
        bus.fwd_hit  = 1'b1;
        bus.fwd_data = q_data[idx];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      q_valid <= '0;
      q_kill  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (pipe_act && q_valid[i] && (q_addr[i] == bus.pipe_addr)) q_kill[i] <= 1'b1;
      end
      if (pop) begin
        q_valid[head] <= 1'b0;
        head          <= head + PW'(1);
      end
      if (enq) begin
        q_valid[tail] <= 1'b1;
        q_kill[tail]  <= 1'b0;
        tail          <= tail + PW'(1);
      end
      count <= count + CW'(enq) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      q_addr[tail] <= bus.mdu_addr;
      q_data[tail] <= bus.mdu_data;
    end
  end
endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios plus random traffic, checked cycle by cycle
// against a queue-based model of the pending results and the register-file writes.
module tb_wb_arbiter;
  localparam int DEPTH = 4;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
    bit          k;
  } ent_t;

  logic clk;
  logic rst;
  wb_arbiter_if #(.DEPTH(DEPTH)) bus ();

  wb_arbiter #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  ent_t        mq[$];
  logic [36:0] exp_q[$];
  logic [31:0] rf_dut[32];
  int          n_checks = 0;
  int          n_fail   = 0;

  // ---- clock / reset ----
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic drive_idle();
    bus.pipe_we   = 1'b0;
    bus.pipe_addr = 5'd0;
    bus.pipe_data = 32'd0;
    bus.mdu_valid = 1'b0;
    bus.mdu_addr  = 5'd0;
    bus.mdu_data  = 32'd0;
    bus.fwd_addr  = 5'd0;
  endtask

  // Holds rst for one cycle starting now (asynchronously, mid-cycle) and checks reset outputs.
  task automatic pulse_reset();
    drive_idle();
    rst = 1'b1;
    @(negedge clk);
    check("rst_pend_count", 64'(bus.pend_count), 64'd0);
    check("rst_rf_we", 64'(bus.rf_we), 64'd0);
    check("rst_fwd_hit", 64'(bus.fwd_hit), 64'd0);
    check("rst_mdu_ready", 64'(bus.mdu_ready), 64'd1);
    mq.delete();
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // One clock cycle: drive inputs, predict from the model, compare at negedge, commit at posedge.
  task automatic step(input bit pwe, input logic [4:0] pa, input logic [31:0] pd,
                      input bit mv, input logic [4:0] ma, input logic [31:0] md,
                      input logic [4:0] fa);
    bit          pact;
    bit          rdy;
    bit          xfer;
    bit          drop;
    bit          ewe;
    bit          enq;
    bit          eh;
    logic [31:0] ed;
    logic [36:0] ew;
    bit          got_we;
    logic [4:0]  got_a;
    logic [31:0] got_d;
    bus.pipe_we   = pwe;
    bus.pipe_addr = pa;
    bus.pipe_data = pd;
    bus.mdu_valid = mv;
    bus.mdu_addr  = ma;
    bus.mdu_data  = md;
    bus.fwd_addr  = fa;

    pact = pwe && (pa != 5'd0);
    rdy  = mq.size() < DEPTH;
    xfer = mv && rdy;
    drop = (ma == 5'd0) || (pact && (pa == ma));
    ewe  = 1'b0;
    ew   = '0;
    if (pact) begin
      ewe = 1'b1;
      ew  = {pa, pd};
    end else if (mq.size() > 0) begin
      ewe = !mq[0].k;
      ew  = {mq[0].a, mq[0].d};
    end else if (xfer && !drop) begin
      ewe = 1'b1;
      ew  = {ma, md};
    end
    enq = xfer && !drop && !(!pact && mq.size() == 0);
    eh  = 1'b0;
    ed  = 32'd0;
    if (fa != 5'd0) begin
      foreach (mq[i]) begin
        if (!mq[i].k && mq[i].a == fa) begin
          eh = 1'b1;
          ed = mq[i].d;
        end
      end
    end
    if (ewe) exp_q.push_back(ew);

    @(negedge clk);
    check("mdu_ready", 64'(bus.mdu_ready), 64'(rdy));
    check("pend_count", 64'(bus.pend_count), 64'(mq.size()));
    check("rf_we", 64'(bus.rf_we), 64'(ewe));
    if (bus.rf_we) begin
      if (exp_q.size() == 0) check("rf_spurious", 64'd1, 64'd0);
      else check("rf_write", 64'({bus.rf_addr, bus.rf_data}), 64'(exp_q.pop_front()));
    end else if (ewe) begin
      void'(exp_q.pop_back());
    end
    check("fwd_hit", 64'(bus.fwd_hit), 64'(eh));
    check("fwd_data", 64'(bus.fwd_data), 64'(ed));
    got_we = bus.rf_we;
    got_a  = bus.rf_addr;
    got_d  = bus.rf_data;

    @(posedge clk);
    if (got_we) rf_dut[got_a] = got_d;
    if (pact) begin
      foreach (mq[i]) if (mq[i].a == pa) mq[i].k = 1'b1;
    end
    if (!pact && mq.size() > 0) void'(mq.pop_front());
    if (enq) mq.push_back('{a: ma, d: md, k: 1'b0});
    #1;
  endtask

  task automatic idle_steps(input int n, input logic [4:0] fa);
    for (int i = 0; i < n; i++) step(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, fa);
  endtask

  initial begin
    int mi;
    foreach (rf_dut[i]) rf_dut[i] = 32'd0;
    drive_idle();
    rst = 1'b1;
    #1;
    check("por_pend_count", 64'(bus.pend_count), 64'd0);
    check("por_mdu_ready", 64'(bus.mdu_ready), 64'd1);
    @(posedge clk);
    pulse_reset();

    // Idle bypass of an MDU result.
    step(0, 5'd0, 32'd0, 1, 5'd5, 32'h1234, 5'd0);
    check("bypass_r5", 64'(rf_dut[5]), 64'h1234);

    // Collision of pipe and MDU: MDU queued, then drained.
    step(1, 5'd3, 32'hAAAA, 1, 5'd7, 32'hBBBB, 5'd7);
    step(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 5'd7);
    check("r3_written", 64'(rf_dut[3]), 64'hAAAA);
    check("r7_written", 64'(rf_dut[7]), 64'hBBBB);

    // Pipe busy while MDU streams r1..r6; producer holds a result until accepted.
    mi = 1;
    for (int c = 0; c < 6; c++) begin
      bit acc;
      acc = mq.size() < DEPTH;
      step(1, 5'd20, 32'h2000 + c, 1, 5'(mi), 32'h100 + mi, 5'(mi));
      if (acc) mi++;
    end
    check("stream_accepts", 64'(mi), 64'd5);
    idle_steps(5, 5'd2);
    check("drain_r4", 64'(rf_dut[4]), 64'h104);

    // Kill of a pending entry by a younger pipe write.
    step(1, 5'd20, 32'h1, 1, 5'd9, 32'h11, 5'd9);
    step(1, 5'd9, 32'h22, 0, 5'd0, 32'd0, 5'd9);
    idle_steps(3, 5'd9);
    check("r9_final", 64'(rf_dut[9]), 64'h22);

    // Youngest-match forwarding.
    step(1, 5'd20, 32'h1, 1, 5'd4, 32'h1, 5'd4);
    step(1, 5'd20, 32'h1, 1, 5'd4, 32'h2, 5'd4);
    step(1, 5'd20, 32'h1, 0, 5'd0, 32'd0, 5'd4);
    step(1, 5'd20, 32'h1, 0, 5'd0, 32'd0, 5'd0);
    idle_steps(3, 5'd4);

    // Reset with two pending entries discards them.
    step(1, 5'd20, 32'h1, 1, 5'd12, 32'h55, 5'd12);
    step(1, 5'd20, 32'h1, 1, 5'd13, 32'h66, 5'd13);
    pulse_reset();
    idle_steps(3, 5'd12);
    check("r12_not_written", 64'(rf_dut[12]), 64'd0);
    check("r13_not_written", 64'(rf_dut[13]), 64'd0);

    // Random traffic over a small register range to force collisions.
    for (int c = 0; c < 500; c++) begin
      step($urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom,
           $urandom_range(0, 2) != 0, 5'($urandom_range(0, 7)), $urandom,
           5'($urandom_range(0, 7)));
      if ($urandom_range(0, 199) == 0) pulse_reset();
    end
    idle_steps(DEPTH + 1, 5'd0);
    check("final_empty", 64'(bus.pend_count), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter: DEPTH, 4, pending-result FIFO entries (power of two, >=2).
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 pipe_we  input  1  main-pipeline writeback request.
REQ-005 pipe_addr  input  5  pipeline destination register.
REQ-006 pipe_data  input  32  pipeline writeback data.
REQ-007 mdu_valid  input  1  multi-cycle unit result valid.
REQ-008 mdu_ready  output  1  arbiter can accept an MDU result.
REQ-009 mdu_addr  input  5  MDU destination register.
REQ-010 mdu_data  input  32  MDU result data.
REQ-011 rf_we  output  1  register-file write enable.
REQ-012 rf_addr  output  5  register-file write address.
REQ-013 rf_data  output  32  register-file write data.
REQ-014 fwd_addr  input  5  bypass lookup register.
REQ-015 fwd_hit  output  1  pending FIFO value exists for fwd_addr.
REQ-016 fwd_data  output  32  youngest pending value for fwd_addr.
REQ-017 pend_count  output  $clog2(DEPTH)+1  live FIFO occupancy.

Function
REQ-018 rf_we/rf_addr/rf_data SHALL be combinational from current inputs and FIFO state; the register file commits them at the same rising edge; at most one write per cycle.
REQ-019 Pipe write is active when pipe_we=1 and pipe_addr!=0; it SHALL always win and SHALL never be stalled.
REQ-020 Priority when no active pipe write: valid FIFO head, then an MDU result accepted this cycle with the FIFO empty (direct bypass, not enqueued).
REQ-021 mdu_ready SHALL equal (pend_count<DEPTH); a transfer occurs when mdu_valid and mdu_ready are both 1.
REQ-022 An accepted MDU result SHALL be enqueued at the tail unless it is written directly per REQ-020 or discarded per REQ-023/REQ-024.
REQ-023 An MDU result with mdu_addr=0 SHALL be accepted and discarded.
REQ-024 An MDU result accepted in the same cycle as an active pipe write to the same address SHALL be discarded (pipe value is younger).
REQ-025 An active pipe write to address A SHALL set the kill bit on every FIFO entry holding address A in that cycle.
REQ-026 The head SHALL pop in any cycle without an active pipe write; a killed head pops with rf_we=0.
REQ-027 Simultaneous enqueue and pop SHALL leave pend_count unchanged; pointers wrap modulo DEPTH.
REQ-028 pipe_we=1 with pipe_addr=0 SHALL be treated as no pipe write (rf_we from FIFO/MDU path allowed).
REQ-029 fwd_hit SHALL be 1 when fwd_addr!=0 and any non-killed FIFO entry matches; fwd_data SHALL be the youngest match, else 0.
REQ-030 Full FIFO: mdu_ready=0; no entry is overwritten; an entry drains at the next cycle without a pipe write.

Reset
REQ-031 While rst=1: FIFO empty, pointers 0, kill bits clear, pend_count=0, rf_we=0, fwd_hit=0, mdu_ready=1.
REQ-032 Assertion of rst mid-operation SHALL discard all pending entries without writing them.

Verification
REQ-033 Idle, MDU result r5=0x1234 -> same cycle rf_we=1, rf_addr=5, rf_data=0x1234, pend_count stays 0.
REQ-034 Pipe r3=0xAAAA and MDU r7=0xBBBB same cycle -> r3 written; next idle cycle r7=0xBBBB written; pend_count 1 then 0.
REQ-035 Pipe held writing for 6 cycles while MDU streams r1..r6 (DEPTH=4) -> mdu_ready drops after 4 accepts; drains r1..r4 in order after pipe idles.
REQ-036 FIFO holds r9=0x11; pipe writes r9=0x22 -> fwd_hit for r9 goes 0; killed entry pops later with rf_we=0; final r9=0x22.
REQ-037 FIFO holds r4=0x1, r4=0x2 -> fwd_addr=4 gives fwd_hit=1, fwd_data=0x2; fwd_addr=0 gives fwd_hit=0.
REQ-038 Two pending entries, rst pulsed -> pend_count=0, rf_we=0, no pending write reaches the register file.
